clk_div_monitor: RTL and testbench

Downstream checker for the frequency-divider output. It samples the divided clock as a data signal in the clk_in domain and measures the period and high time of every cycle, in clk_in cycles. It flags period mismatches and a stopped (stuck) divided clock. Used on-board and in benches to qualify divider settings before the divided clock feeds later stages.

---
 rtl/clk_div_monitor.sv | 153 +++++++++++++++
 tb/tb_clk_div_monitor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock sampled in the clk_in domain,
// flagging period mismatches against EXP_PERIOD and a stopped divided clock.
module clk_div_monitor #(
    parameter int W          = 8,
    parameter int EXP_PERIOD = 11,
    parameter int TIMEOUT    = 64
) (
    input  logic         clk_in,
    input  logic         clr,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_cnt,
    output logic         meas_valid,
    output logic         err_period,
    output logic         stuck,
    output logic [15:0]  edge_cnt
);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARM      = 2'd1,
        MEAS     = 2'd2
    } state_t;

    localparam logic [W-1:0] CNT_MAX   = '1;
    localparam logic [W-1:0] EXP_W     = W'(EXP_PERIOD);
    localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);

    state_t       state_q, state_d;
    logic         s1_q, s1_d;
    logic         s2_q, s2_d;
    logic         s3_q, s3_d;
    logic [1:0]   fill_q, fill_d;
    logic [W-1:0] run_cnt_q, run_cnt_d;
    logic [W-1:0] hi_acc_q, hi_acc_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] high_cnt_q, high_cnt_d;
    logic         meas_valid_q, meas_valid_d;
    logic         err_period_q, err_period_d;
    logic         stuck_q, stuck_d;
    logic [15:0]  edge_cnt_q, edge_cnt_d;
    logic         rise;
    logic         sync_filled;

    assign rise = s2_q & ~s3_q;

    // s2 only reflects a genuine sample of sig_in once two clocks have passed since clr,
    // so WAIT_LOW must not treat the reset zeros as a real low level.
    assign sync_filled = (fill_q == 2'd2);

    always_comb begin
        state_d      = state_q;
        s1_d         = sig_in;
        s2_d         = s1_q;
        s3_d         = s2_q;
        fill_d       = sync_filled ? fill_q : fill_q + 2'd1;
        run_cnt_d    = run_cnt_q;
        hi_acc_d     = hi_acc_q;
        period_d     = period_q;
        high_cnt_d   = high_cnt_q;
        meas_valid_d = 1'b0;
        err_period_d = err_period_q;
        stuck_d      = stuck_q;
        edge_cnt_d   = edge_cnt_q;

        case (state_q)
            WAIT_LOW: begin
                if (sync_filled && !s2_q) begin
                    state_d = ARM;
                end
            end

            ARM: begin
                if (rise) begin
                    state_d    = MEAS;
                    run_cnt_d  = {{(W-1){1'b0}}, 1'b1};
                    hi_acc_d   = {{(W-1){1'b0}}, 1'b1};
                    edge_cnt_d = edge_cnt_q + 16'd1;
                    stuck_d    = 1'b0;
                end
            end

            MEAS: begin
                // A rise on the timeout cycle still closes a valid measurement.
                if (rise) begin
                    period_d     = run_cnt_q;
                    high_cnt_d   = hi_acc_q;
                    meas_valid_d = 1'b1;
                    if (run_cnt_q != EXP_W) begin
                        err_period_d = 1'b1;
                    end
                    run_cnt_d    = {{(W-1){1'b0}}, 1'b1};
                    hi_acc_d     = {{(W-1){1'b0}}, 1'b1};
                    edge_cnt_d   = edge_cnt_q + 16'd1;
                end else if (run_cnt_q == TIMEOUT_W) begin
                    stuck_d = 1'b1;
                    state_d = WAIT_LOW;
                end else begin
                    if (run_cnt_q != CNT_MAX) begin
                        run_cnt_d = run_cnt_q + {{(W-1){1'b0}}, 1'b1};
                    end
                    if (s2_q && (hi_acc_q != CNT_MAX)) begin
                        hi_acc_d = hi_acc_q + {{(W-1){1'b0}}, 1'b1};
                    end
                end
            end

            default: begin
                state_d = WAIT_LOW;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (clr) begin
            state_q      <= WAIT_LOW;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            fill_q       <= 2'd0;
            run_cnt_q    <= '0;
            hi_acc_q     <= '0;
            period_q     <= '0;
            high_cnt_q   <= '0;
            meas_valid_q <= 1'b0;
            err_period_q <= 1'b0;
            stuck_q      <= 1'b0;
            edge_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            fill_q       <= fill_d;
            run_cnt_q    <= run_cnt_d;
            hi_acc_q     <= hi_acc_d;
            period_q     <= period_d;
            high_cnt_q   <= high_cnt_d;
            meas_valid_q <= meas_valid_d;
            err_period_q <= err_period_d;
            stuck_q      <= stuck_d;
            edge_cnt_q   <= edge_cnt_d;
        end
    end

    assign period     = period_q;
    assign high_cnt   = high_cnt_q;
    assign meas_valid = meas_valid_q;
    assign err_period = err_period_q;
    assign stuck      = stuck_q;
    assign edge_cnt   = edge_cnt_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed scenarios plus random waves, every cycle compared
// against a model that derives measurements from the recorded sample history.
module tb_clk_div_monitor;

    localparam int W          = 8;
    localparam int EXP_PERIOD = 11;
    localparam int TIMEOUT    = 64;
    localparam int HIST       = 8192;

    logic         clk_in;
    logic         clr;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_cnt;
    logic         meas_valid;
    logic         err_period;
    logic         stuck;
    logic [15:0]  edge_cnt;

    int tests_run;
    int tests_failed;

    clk_div_monitor #(
        .W(W),
        .EXP_PERIOD(EXP_PERIOD),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in(clk_in),
        .clr(clr),
        .sig_in(sig_in),
        .period(period),
        .high_cnt(high_cnt),
        .meas_valid(meas_valid),
        .err_period(err_period),
        .stuck(stuck),
        .edge_cnt(edge_cnt)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Per-edge history of what the bench applied; the model reads the synchronizer view from it.
    logic smp    [HIST];
    logic clr_at [HIST];
    int   cyc;

    int          m_mode;
    int          m_last_rise;
    int          m_period;
    int          m_high;
    logic        m_mv;
    logic        m_err;
    logic        m_stuck;
    logic [15:0] m_edge;

    function automatic logic s2_at(input int x);
        if (x < 2) return 1'b0;
        if (clr_at[x-1] || clr_at[x-2]) return 1'b0;
        return smp[x-2];
    endfunction

    function automatic logic s3_at(input int x);
        if (x < 3) return 1'b0;
        if (clr_at[x-1] || clr_at[x-2] || clr_at[x-3]) return 1'b0;
        return smp[x-3];
    endfunction

    function automatic logic sample_real(input int x);
        if (x < 2) return 1'b0;
        return !(clr_at[x-1] || clr_at[x-2]);
    endfunction

    task automatic modelStep(input logic s, input logic c);
        logic rise;
        int   n;
        int   hsum;
        smp[cyc]    = s;
        clr_at[cyc] = c;
        if (c) begin
            m_mode      = 0;
            m_last_rise = 0;
            m_period    = 0;
            m_high      = 0;
            m_mv        = 1'b0;
            m_err       = 1'b0;
            m_stuck     = 1'b0;
            m_edge      = 16'd0;
        end else begin
            rise = s2_at(cyc) & ~s3_at(cyc);
            m_mv = 1'b0;
            if (m_mode == 0) begin
                if (sample_real(cyc) && !s2_at(cyc)) m_mode = 1;
            end else if (m_mode == 1) begin
                if (rise) begin
                    m_mode      = 2;
                    m_last_rise = cyc;
                    m_edge      = m_edge + 16'd1;
                    m_stuck     = 1'b0;
                end
            end else begin
                n = cyc - m_last_rise;
                if (rise) begin
                    hsum = 0;
                    for (int x = m_last_rise; x < cyc; x++) hsum += int'(s2_at(x));
                    m_period    = n;
                    m_high      = hsum;
                    m_mv        = 1'b1;
                    if (n != EXP_PERIOD) m_err = 1'b1;
                    m_last_rise = cyc;
                    m_edge      = m_edge + 16'd1;
                end else if (n == TIMEOUT) begin
                    m_stuck = 1'b1;
                    m_mode  = 0;
                end
            end
        end
        cyc++;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("period",     32'(period),     32'(m_period));
        checkValue("high_cnt",   32'(high_cnt),   32'(m_high));
        checkValue("meas_valid", 32'(meas_valid), 32'(m_mv));
        checkValue("err_period", 32'(err_period), 32'(m_err));
        checkValue("stuck",      32'(stuck),      32'(m_stuck));
        checkValue("edge_cnt",   32'(edge_cnt),   32'(m_edge));
    endtask

    task automatic applyStimulus(input logic s, input logic c);
        if (cyc >= HIST - 1) begin
            $display("[TB] FAIL history: observed cycle %0d required below %0d", cyc, HIST - 1);
            $fatal(1, "[TB] history overflow");
        end
        sig_in = s;
        clr    = c;
        @(posedge clk_in);
        modelStep(s, c);
        #1;
        checkOutput();
    endtask

    task automatic hold(input logic s, input int n);
        for (int i = 0; i < n; i++) applyStimulus(s, 1'b0);
    endtask

    task automatic runWave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  hi;
        int  lo;
        int  budget;
        logic ph;
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        sig_in       = 1'b0;
        clr          = 1'b0;
        ph           = 1'b0;

        // Nominal 5/6 wave after reset.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
        checkValue("reset_edge_cnt", 32'(edge_cnt), 32'd0);
        checkValue("reset_period", 32'(period), 32'd0);
        hold(1'b0, 4);
        runWave(5, 6, 6);
        checkValue("s1_period", 32'(period), 32'd11);
        checkValue("s1_high", 32'(high_cnt), 32'd5);
        checkValue("s1_err", 32'(err_period), 32'd0);

        // Wrong period, err_period must stay set.
        runWave(4, 8, 4);
        checkValue("s2_period", 32'(period), 32'd12);
        checkValue("s2_high", 32'(high_cnt), 32'd4);
        runWave(5, 6, 3);
        checkValue("s2_err_sticky", 32'(err_period), 32'd1);

        // Stuck high, then recovery.
        hold(1'b1, 80);
        checkValue("s3_stuck", 32'(stuck), 32'd1);
        hold(1'b0, 6);
        runWave(5, 6, 3);
        checkValue("s3_stuck_clear", 32'(stuck), 32'd0);

        // Rise exactly on the timeout count versus one cycle later.
        runWave(10, 54, 3);
        checkValue("to_period64", 32'(period), 32'd64);
        checkValue("to_no_stuck", 32'(stuck), 32'd0);
        runWave(10, 55, 2);

        // sig_in high across reset release.
        hold(1'b1, 2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
        hold(1'b1, 10);
        checkValue("s4_no_edge", 32'(edge_cnt), 32'd0);
        hold(1'b0, 6);
        hold(1'b1, 3);
        checkValue("s4_first_edge", 32'(edge_cnt), 32'd1);
        hold(1'b0, 6);
        runWave(5, 6, 3);

        // Reset mid-period.
        runWave(5, 6, 1);
        hold(1'b1, 3);
        applyStimulus(1'b1, 1'b1);
        checkValue("s5_period", 32'(period), 32'd0);
        checkValue("s5_err", 32'(err_period), 32'd0);
        checkValue("s5_edge", 32'(edge_cnt), 32'd0);
        hold(1'b0, 4);
        runWave(5, 6, 4);

        // Fast toggle and edge counter wrap.
        runWave(1, 1, 10);
        checkValue("s6_period", 32'(period), 32'd2);
        checkValue("s6_high", 32'(high_cnt), 32'd1);
        checkValue("s6_err", 32'(err_period), 32'd1);
        force dut.edge_cnt_q = 16'hFFFF;
        #1;
        release dut.edge_cnt_q;
        m_edge = 16'hFFFF;
        budget = 0;
        while (edge_cnt == 16'hFFFF && budget < 6) begin
            applyStimulus(ph, 1'b0);
            ph = ~ph;
            budget++;
        end
        checkValue("s6_wrap", 32'(edge_cnt), 32'd0);
        runWave(1, 1, 4);

        // Random waves with occasional long highs and resets.
        for (int seg = 0; seg < 30; seg++) begin
            hi = $urandom_range(1, 12);
            lo = $urandom_range(1, 12);
            if ($urandom_range(0, 7) == 0) hi = $urandom_range(60, 75);
            runWave(hi, lo, 1);
            if ($urandom_range(0, 9) == 0) applyStimulus(1'($urandom_range(0, 1)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
